// File: rtl/decoder_seq.sv
// -----------------------------------------------------------------------------
// decoder_seq
//   Registered, parametrised SEL_W-to-2**SEL_W one-hot decoder with enable,
//   a load strobe for direct decoding, and an auto-scan mode. Scan mode steps
//   the active line through every output, holding each one for HOLD cycles.
//
// Parameters
//   SEL_W       select width; output width is 2**SEL_W (derived)
//   HOLD        scan dwell per line in clock cycles, legal range 1..256
//   ACTIVE_LOW  1 = active line driven 0 and inactive lines driven 1
//
// Ports
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset
//   en_i     block enable; 0 returns the block to IDLE
//   mode_i   0 = decode (load) mode, 1 = scan mode
//   load_i   decode-mode strobe: capture sel_i on this edge
//   sel_i    select index
//   x_o      registered one-hot output (polarity per ACTIVE_LOW)
//   idx_o    index of the currently active line
//   valid_o  1 when x_o has exactly one active line
//   wrap_o   one-cycle pulse when the scan wraps from the last line to 0
// -----------------------------------------------------------------------------
module decoder_seq #(
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned HOLD       = 1,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic                    mode_i,
  input  logic                    load_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [(1<<SEL_W)-1:0]   x_o,
  output logic [SEL_W-1:0]        idx_o,
  output logic                    valid_o,
  output logic                    wrap_o
);

  localparam int unsigned OUT_W   = 1 << SEL_W;
  // A HOLD of 1 still needs a 1-bit counter so the vector is never zero-width.
  localparam int unsigned DWELL_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(HOLD - 1);
  localparam logic [SEL_W-1:0]   IDX_LAST   = SEL_W'(OUT_W - 1);
  localparam logic [OUT_W-1:0]   X_IDLE     = {OUT_W{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    SCAN   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     idx_q,   idx_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [OUT_W-1:0]     x_q,     x_d;
  logic                 valid_q, valid_d;
  logic                 wrap_q,  wrap_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every register is written with <= so all flops update together from
  // the values present before the edge, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
      x_q     <= X_IDLE;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority on every edge: en_i low, then mode_i, then load_i.
  // ---------------------------------------------------------------------------
  // NOTE: defaults are assigned first so every path drives every signal;
  // a path that left one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;

    unique case (state_q)
      IDLE: begin
        if (en_i && mode_i) begin
          state_d = SCAN;
          idx_d   = '0;
          dwell_d = '0;
        end else if (en_i && load_i) begin
          state_d = DECODE;
          idx_d   = sel_i;
        end
      end

      DECODE: begin
        if (!en_i) begin
          state_d = IDLE;           // idx retained while idle
        end else if (mode_i) begin
          state_d = SCAN;
          idx_d   = '0;
          dwell_d = '0;
        end else if (load_i) begin
          idx_d   = sel_i;
        end
      end

      SCAN: begin
        if (!en_i) begin
          state_d = IDLE;
          dwell_d = '0;
        end else if (!mode_i) begin
          // Leaving scan freezes the current line unless a load lands on the
          // same edge.
          state_d = DECODE;
          dwell_d = '0;
          if (load_i) idx_d = sel_i;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          idx_d   = idx_q + SEL_W'(1);  // natural wrap modulo OUT_W
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
        dwell_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: computed from the next state so the registered outputs line
  // up with the state they describe, with no input-to-output combinational path.
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] hot_d;

  always_comb begin
    valid_d = (state_d != IDLE);
    hot_d   = '0;
    if (valid_d) hot_d[idx_d] = 1'b1;
    x_d     = ACTIVE_LOW ? ~hot_d : hot_d;
    // Wrap only on a genuine step out of the last line while scanning; the
    // initial scan entry also lands on line 0 but must not pulse.
    wrap_d  = (state_q == SCAN) && (state_d == SCAN) &&
              (dwell_q == DWELL_LAST) && (idx_q == IDX_LAST);
  end

  assign x_o     = x_q;
  assign idx_o   = idx_q;
  assign valid_o = valid_q;
  assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_decoder_seq.sv
// -----------------------------------------------------------------------------
// tb_decoder_seq
//   Drives five decoder_seq configurations from one shared stimulus stream and
//   compares every output each cycle against a behavioural model. The model
//   tracks scan position as "cycles since scan entry" and derives the line and
//   the wrap pulse arithmetically from HOLD and the output width.
// -----------------------------------------------------------------------------
module tb_decoder_seq;

  localparam int NDUT = 5;
  localparam int SW [NDUT] = '{3, 3, 3, 4, 1};
  localparam int HL [NDUT] = '{1, 1, 3, 2, 1};
  localparam bit AL [NDUT] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       en    = 1'b0;
  logic       mode  = 1'b0;
  logic       load  = 1'b0;
  logic [3:0] sel   = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  logic [7:0]  x0, x1, x2;
  logic [15:0] x3;
  logic [1:0]  x4;
  logic [2:0]  i0, i1, i2;
  logic [3:0]  i3;
  logic [0:0]  i4;
  logic [NDUT-1:0] v, w;

  decoder_seq #(.SEL_W(3), .HOLD(1), .ACTIVE_LOW(1'b0)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode), .load_i(load),
    .sel_i(sel[2:0]), .x_o(x0), .idx_o(i0), .valid_o(v[0]), .wrap_o(w[0]));
  decoder_seq #(.SEL_W(3), .HOLD(1), .ACTIVE_LOW(1'b1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode), .load_i(load),
    .sel_i(sel[2:0]), .x_o(x1), .idx_o(i1), .valid_o(v[1]), .wrap_o(w[1]));
  decoder_seq #(.SEL_W(3), .HOLD(3), .ACTIVE_LOW(1'b0)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode), .load_i(load),
    .sel_i(sel[2:0]), .x_o(x2), .idx_o(i2), .valid_o(v[2]), .wrap_o(w[2]));
  decoder_seq #(.SEL_W(4), .HOLD(2), .ACTIVE_LOW(1'b0)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode), .load_i(load),
    .sel_i(sel[3:0]), .x_o(x3), .idx_o(i3), .valid_o(v[3]), .wrap_o(w[3]));
  decoder_seq #(.SEL_W(1), .HOLD(1), .ACTIVE_LOW(1'b0)) u4 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode), .load_i(load),
    .sel_i(sel[0:0]), .x_o(x4), .idx_o(i4), .valid_o(v[4]), .wrap_o(w[4]));

  logic [31:0] x_obs   [NDUT];
  logic [31:0] idx_obs [NDUT];
  assign x_obs[0] = 32'(x0);  assign idx_obs[0] = 32'(i0);
  assign x_obs[1] = 32'(x1);  assign idx_obs[1] = 32'(i1);
  assign x_obs[2] = 32'(x2);  assign idx_obs[2] = 32'(i2);
  assign x_obs[3] = 32'(x3);  assign idx_obs[3] = 32'(i3);
  assign x_obs[4] = 32'(x4);  assign idx_obs[4] = 32'(i4);

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int st;      // 0 idle, 1 decode, 2 scan
    int idx;
    int t;       // cycles spent in scan since entry
    bit valid;
    bit wrap;
  } model_t;

  model_t m [NDUT];

  function automatic model_t model_reset();
    model_t r;
    r.st = 0; r.idx = 0; r.t = 0; r.valid = 1'b0; r.wrap = 1'b0;
    return r;
  endfunction

  function automatic model_t model_step(model_t c, int sw, int hold,
                                        bit e, bit md, bit ld, int s_in);
    model_t n = c;
    int out_w = 1 << sw;
    int s     = s_in % out_w;
    n.wrap = 1'b0;
    if (c.st == 0) begin
      if (e && md)      begin n.st = 2; n.idx = 0; n.t = 0; end
      else if (e && ld) begin n.st = 1; n.idx = s; end
    end else if (c.st == 1) begin
      if (!e)           n.st = 0;
      else if (md)      begin n.st = 2; n.idx = 0; n.t = 0; end
      else if (ld)      n.idx = s;
    end else begin
      if (!e)           n.st = 0;
      else if (!md)     begin n.st = 1; if (ld) n.idx = s; end
      else begin
        n.t    = c.t + 1;
        n.idx  = (n.t / hold) % out_w;
        n.wrap = (n.t % (hold * out_w)) == 0;
      end
    end
    n.valid = (n.st != 0);
    return n;
  endfunction

  function automatic logic [31:0] exp_x(model_t c, int sw, bit al);
    logic [31:0] mask = (32'd1 << (1 << sw)) - 32'd1;
    logic [31:0] h    = c.valid ? (32'd1 << c.idx) : 32'd0;
    return al ? (~h & mask) : h;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("u%0d.x", k),     x_obs[k],      exp_x(m[k], SW[k], AL[k]));
      check($sformatf("u%0d.idx", k),   idx_obs[k],    32'(m[k].idx));
      check($sformatf("u%0d.valid", k), 32'(v[k]),     32'(m[k].valid));
      check($sformatf("u%0d.wrap", k),  32'(w[k]),     32'(m[k].wrap));
    end
  endtask

  // One clock: advance the model on the edge, then sample 1 ns later.
  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) begin
      if (!rst_n) m[k] = model_reset();
      else        m[k] = model_step(m[k], SW[k], HL[k], en, mode, load, int'(sel));
    end
    #1;
    compare_all();
  endtask

  // Assert reset between edges and confirm the outputs clear without a clock.
  task automatic async_reset_pulse();
    #3;
    rst_n = 1'b0;
    for (int k = 0; k < NDUT; k++) m[k] = model_reset();
    #1;
    compare_all();
    check("async_rst_x_al0", x_obs[0], 32'h00);
    check("async_rst_x_al1", x_obs[1], 32'hFF);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int k = 0; k < NDUT; k++) m[k] = model_reset();

    // Reset / idle
    #1 rst_n = 1'b0;
    #1;
    compare_all();
    check("rst_x_al0", x_obs[0], 32'h00);
    check("rst_x_al1", x_obs[1], 32'hFF);
    cycle();
    cycle();
    @(negedge clk) rst_n = 1'b1;
    cycle();

    // Decode: 5, then back-to-back 2 and 7, then hold
    en = 1'b1; mode = 1'b0; load = 1'b1; sel = 4'd5;
    cycle();
    check("dec_sel5_x", x_obs[0], 32'h20);
    check("dec_sel5_idx", idx_obs[0], 32'd5);
    sel = 4'd2;  cycle();  check("dec_sel2_x", x_obs[0], 32'h04);
    sel = 4'd7;  cycle();  check("dec_sel7_x", x_obs[0], 32'h80);
    load = 1'b0; sel = 4'd3;
    cycle();               check("dec_hold_x", x_obs[0], 32'h80);
    load = 1'b1; sel = 4'd15;
    cycle();
    check("dec_w4_sel15", x_obs[3], 32'h8000);
    check("dec_w1_sel1",  x_obs[4], 32'h2);
    load = 1'b0;

    // Scan entry and first sweep; u2 (HOLD=3) reaches line 4 after 12 steps
    mode = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      cycle();
      if (i <= 8) begin
        check($sformatf("scan_h1_x_c%0d", i), x_obs[0], 32'd1 << (i % 8));
        check($sformatf("scan_h1_wrap_c%0d", i), 32'(w[0]), 32'(i == 8));
        check($sformatf("scan_w1_x_c%0d", i), x_obs[4], (i % 2) ? 32'h2 : 32'h1);
        check($sformatf("scan_w1_wrap_c%0d", i), 32'(w[4]),
              32'((i > 0) && (i % 2 == 0)));
      end
    end
    check("scan_h3_idx4", idx_obs[2], 32'd4);
    mode = 1'b0;
    cycle();  check("scan_to_dec_x", x_obs[2], 32'h10);
    cycle();  check("dec_frozen_x",  x_obs[2], 32'h10);

    // Disable in the middle of a scan
    mode = 1'b1;
    repeat (4) cycle();
    en = 1'b0;
    cycle();
    check("dis_x",     x_obs[0], 32'h00);
    check("dis_valid", 32'(v[0]), 32'd0);

    // Asynchronous reset mid-scan, then restart from line 0
    en = 1'b1; mode = 1'b1;
    repeat (5) cycle();
    async_reset_pulse();
    cycle();
    @(negedge clk) rst_n = 1'b1;
    cycle();
    check("restart_x", x_obs[0], 32'h01);
    check("restart_wrap", 32'(w[0]), 32'd0);

    // Randomised traffic with occasional asynchronous resets
    for (int i = 0; i < 1500; i++) begin
      en   = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      load = $urandom_range(0, 1) == 1;
      sel  = 4'($urandom_range(0, 15));
      cycle();
      if ($urandom_range(0, 99) == 0) begin
        async_reset_pulse();
        #1 rst_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
